mcount_sys: RTL and testbench

- Parametrised loadable down-counter that sequences the systolic multiply loop in the GPU datapath.
- It is the generalised successor of the fixed 4-bit width counter:
  - width is a parameter;
  - adds a zero-hold (no wrap) rule and an optional auto-reload mode;
  - adds registered done/busy status and a saturating pass counter.
- Sits between the instruction decode (load/enable) and the systolic MAC array (terminal flags).

---
 rtl/mcount_pkg.sv | 14 +
 rtl/mcount_dec.sv | 34 +++
 rtl/mcount_sys.sv | 108 ++++++++++
 tb/tb_mcount_sys.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcount_pkg.sv
// Shared definitions for the loop-count sequencer family.
// Holds the FSM state encoding and the default count/pass widths
// reused by the multiplier top level.
package mcount_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_PWIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mcount_dec.sv
// Decrement-with-borrow chain plus terminal decodes.
// Ports:
//   value   in  WIDTH  operand
//   dec     out WIDTH  value - 1 (wraps; caller decides whether to use it)
//   is_one  out 1      value == 1
//   is_zero out 1      value == 0
module mcount_dec #(
  parameter int unsigned WIDTH = mcount_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] dec,
  output logic             is_one,
  output logic             is_zero
);

  logic [WIDTH:0] borrow;

  // Ripple borrow: a bit flips while every lower bit is zero.
  // The borrow out of the top bit means the operand was all zeros.
  always_comb begin
    borrow    = '0;
    dec       = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      dec[i]      = value[i] ^ borrow[i];
      borrow[i+1] = borrow[i] & ~value[i];
    end
  end

  assign is_zero = borrow[WIDTH];
  // Bit 0 set and the borrow from the next bit up would reach the top.
  assign is_one  = value[0] & (value[WIDTH-1:1] == '0);

endmodule

// File: rtl/mcount_sys.sv
// Loadable, zero-holding down-counter that sequences the systolic
// multiply loop, with optional auto-reload, done pulse and a
// saturating pass counter.
// Ports:
//   clk, resetl   clock, async active-low reset
//   cnten         decrement enable
//   cntld         load from mwidth (wins over cnten)
//   mwidth        load value / loop length
//   autorl        on terminal, reload last loaded value and keep running
//   count         count register
//   count1/count0 combinational decodes of count (==1 / ==0)
//   busy          registered, FSM in RUN
//   done          registered one-cycle pulse per completed pass
//   passes        registered, saturating passes since last load
module mcount_sys
  import mcount_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              cnten,
  input  logic              cntld,
  input  logic [WIDTH-1:0]  mwidth,
  input  logic              autorl,
  output logic [WIDTH-1:0]  count,
  output logic              count1,
  output logic              count0,
  output logic              busy,
  output logic              done,
  output logic [PWIDTH-1:0] passes
);

  state_t            state_q, state_n;
  logic [WIDTH-1:0]  count_q, count_n;
  logic [WIDTH-1:0]  reload_q, reload_n;
  logic [PWIDTH-1:0] passes_q, passes_n;
  logic              done_q, done_n;

  logic [WIDTH-1:0]  count_dec;
  logic              is_one;
  logic              is_zero;
  logic [PWIDTH-1:0] passes_inc;

  mcount_dec #(.WIDTH(WIDTH)) u_dec (
    .value   (count_q),
    .dec     (count_dec),
    .is_one  (is_one),
    .is_zero (is_zero)
  );

  // Pass counter sticks at all-ones.
  assign passes_inc = (&passes_q) ? passes_q : passes_q + PWIDTH'(1);

  // Next-state: load > decrement > hold; done defaults low every cycle.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    passes_n = passes_q;
    done_n   = 1'b0;
    if (cntld) begin
      count_n  = mwidth;
      reload_n = mwidth;
      passes_n = '0;
      state_n  = (mwidth != '0) ? ST_RUN : ST_IDLE;
    end else if (cnten && (state_q == ST_RUN) && !is_zero) begin
      if (is_one) begin
        done_n   = 1'b1;
        passes_n = passes_inc;
        if (autorl) begin
          count_n = reload_q;
        end else begin
          count_n = '0;
          state_n = ST_IDLE;
        end
      end else begin
        count_n = count_dec;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      passes_q <= passes_n;
      done_q   <= done_n;
    end
  end

  assign count  = count_q;
  assign count1 = is_one;
  assign count0 = is_zero;
  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign passes = passes_q;

endmodule

// File: tb/tb_mcount_sys.sv
// Scoreboard bench for mcount_sys: the driver pushes the reference
// model's expected post-edge outputs; the monitor pops and compares
// one entry after every rising edge.
module tb_mcount_sys;

  localparam int W  = 4;
  localparam int PW = 2;
  localparam int CMAX = (1 << W) - 1;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct {
    int count;
    int c1;
    int c0;
    int busy;
    int done;
    int passes;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetl = 1'b0;
  logic          cnten = 1'b0;
  logic          cntld = 1'b0;
  logic [W-1:0]  mwidth = '0;
  logic          autorl = 1'b0;
  logic [W-1:0]  count;
  logic          count1, count0, busy, done;
  logic [PW-1:0] passes;

  mcount_sys #(.WIDTH(W), .PWIDTH(PW)) dut (
    .clk    (clk),
    .resetl (resetl),
    .cnten  (cnten),
    .cntld  (cntld),
    .mwidth (mwidth),
    .autorl (autorl),
    .count  (count),
    .count1 (count1),
    .count0 (count0),
    .busy   (busy),
    .done   (done),
    .passes (passes)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: plain integers.
  int  m_count = 0;
  int  m_reload = 0;
  bit  m_running = 0;
  int  m_passes = 0;
  bit  m_done = 0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // One clock of the reference model, applied with the same inputs as the DUT.
  task automatic model_step(input bit rl, input bit ld, input bit en,
                            input int mw, input bit ar);
    if (!rl) begin
      m_count = 0; m_reload = 0; m_running = 0; m_passes = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (ld) begin
        m_count = mw; m_reload = mw; m_passes = 0; m_running = (mw != 0);
      end else if (en && m_running && m_count > 0) begin
        if (m_count == 1) begin
          m_done = 1;
          m_passes = (m_passes + 1 > PMAX) ? PMAX : m_passes + 1;
          if (ar) m_count = m_reload;
          else begin
            m_count = 0;
            m_running = 0;
          end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the expectation.
  task automatic cyc(input bit rl, input bit ld, input bit en,
                     input int mw, input bit ar);
    exp_t e;
    bit   was_out_of_reset;
    @(negedge clk);
    was_out_of_reset = resetl;
    resetl = rl;
    cntld  = ld;
    cnten  = en;
    mwidth = W'(mw);
    autorl = ar;
    if (!rl && was_out_of_reset) begin
      // Reset must take effect without waiting for a clock edge.
      #1;
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_passes", int'(passes), 0);
    end
    model_step(rl, ld, en, mw, ar);
    e.count  = m_count;
    e.c1     = (m_count == 1);
    e.c0     = (m_count == 0);
    e.busy   = m_running;
    e.done   = m_done;
    e.passes = m_passes;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", int'(count), e.count);
        chk("count1", int'(count1), e.c1);
        chk("count0", int'(count0), e.c0);
        chk("busy", int'(busy), e.busy);
        chk("done", int'(done), e.done);
        chk("passes", int'(passes), e.passes);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    // Power-on reset.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Reset mid-run, then zero-hold with cnten.
    cyc(1, 1, 0, 7, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);

    // One-shot from 3.
    cyc(1, 1, 0, 3, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0);

    // Auto-reload from 2.
    cyc(1, 1, 0, 2, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 1);

    // Load priority over decrement at count 4.
    cyc(1, 1, 0, 6, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 9, 0);
    cyc(1, 0, 0, 0, 0);

    // Boundary: zero load.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);

    // Boundary: all-ones load run to terminal.
    cyc(1, 1, 0, CMAX, 0);
    for (int i = 0; i < CMAX + 2; i++) cyc(1, 0, 1, 0, 0);

    // Boundary: reload of 1 -> done every cycle, passes saturate.
    cyc(1, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 0);

    // Stall from 3.
    cyc(1, 1, 0, 3, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      bit rl, ld, en, ar;
      int mw;
      rl = ($urandom_range(0, 63) != 0);
      ld = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1) != 0;
      mw = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, CMAX));
      cyc(rl, ld, en, mw, ar);
    end
    cyc(1, 0, 0, 0, 0);

    // Let the monitor consume every queued expectation.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
